// File: rtl/fetch_ctrl.sv
// Fetch controller: issues ROM reads at prog_ctr, buffers returned words for decode and
// steers the PC block on start/branch/halt. Optional branch target LUT: BRANCH_LUT_EN.
module fetch_ctrl #(
    parameter int D = 9,
    parameter int W = 9
`ifdef BRANCH_LUT_EN
    ,
    parameter int L = 5
`endif
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [D-1:0] start_addr,
    input  logic [D-1:0] prog_ctr,
    output logic         pc_hold,
    output logic         reljump_en,
    output logic         absjump_en,
    output logic [D-1:0] target,
    output logic [D-1:0] imem_addr,
    input  logic [W-1:0] imem_rdata,
    output logic         ins_valid,
    input  logic         ins_ready,
    output logic [W-1:0] ins_data,
    output logic [D-1:0] ins_pc,
    input  logic         br_valid,
    input  logic         br_taken,
    input  logic         br_rel,
    input  logic [D-1:0] br_off,
    input  logic [D-1:0] br_target,
    input  logic         halt,
    output logic         done
`ifdef BRANCH_LUT_EN
    ,
    input  logic         lut_we,
    input  logic [L-1:0] lut_waddr,
    input  logic [D-1:0] lut_wdata
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]   state_r;
    logic         done_r;
    logic [1:0]   count_r;
    logic         inflight_r;
    logic [D-1:0] inflight_pc_r;
    logic [W-1:0] data0_r, data1_r;
    logic [D-1:0] pc0_r, pc1_r;

    logic         pop_s, halt_ev_s, br_ev_s, flush_s, issue_s, pc_hold_s;
    logic [2:0]   occ_s;
    logic [D-1:0] abs_tgt_s, rel_tgt_s;

`ifdef BRANCH_LUT_EN
    logic [D-1:0] lut_r [2**L];

    // Branch target table, written by software, intentionally without reset
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_r[lut_waddr] <= lut_wdata;
        end
    end

    assign abs_tgt_s = lut_r[br_target[L-1:0]];
`else
    assign abs_tgt_s = br_target;
`endif

    assign ins_valid = (count_r != 2'd0);
    assign ins_data  = data0_r;
    assign ins_pc    = pc0_r;
    assign imem_addr = prog_ctr;
    assign done      = done_r;
    assign pc_hold   = pc_hold_s;

    // Event decode, occupancy-based hold and jump drive toward the PC block
    always_comb begin
        pop_s      = ins_valid && ins_ready;
        halt_ev_s  = pop_s && halt && !start;
        br_ev_s    = pop_s && br_valid && br_taken && !halt && !start;
        flush_s    = start || halt_ev_s || br_ev_s;
        // Words owned after this edge: buffered + returning - consumed
        occ_s      = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        pc_hold_s  = (state_r != ST_RUN) || (occ_s >= 3'd2);
        issue_s    = (state_r == ST_RUN) && !pc_hold_s && !flush_s;
        // Relative offset re-based so the PC lands at ins_pc + br_off
        rel_tgt_s  = pc0_r + br_off - prog_ctr;
        reljump_en = 1'b0;
        absjump_en = 1'b0;
        target     = '0;
        if (start) begin
            absjump_en = 1'b1;
            target     = start_addr;
        end else if (br_ev_s) begin
            if (br_rel) begin
                reljump_en = 1'b1;
                target     = rel_tgt_s;
            end else begin
                absjump_en = 1'b1;
                target     = abs_tgt_s;
            end
        end else begin
            target = '0;
        end
    end

    // Run state and done flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
        end else if (start) begin
            state_r <= ST_RUN;
            done_r  <= 1'b0;
        end else if (halt_ev_s) begin
            state_r <= ST_HALT;
            done_r  <= 1'b1;
        end
    end

    // Two-entry buffer with entry 0 as head; returning ROM word is dropped on flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r       <= 2'd0;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            data0_r       <= '0;
            data1_r       <= '0;
            pc0_r         <= '0;
            pc1_r         <= '0;
        end else if (flush_s) begin
            count_r    <= 2'd0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r    <= issue_s;
            inflight_pc_r <= prog_ctr;
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        data0_r <= imem_rdata;
                        pc0_r   <= inflight_pc_r;
                    end else begin
                        data1_r <= imem_rdata;
                        pc1_r   <= inflight_pc_r;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    data0_r <= data1_r;
                    pc0_r   <= pc1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        data0_r <= imem_rdata;
                        pc0_r   <= inflight_pc_r;
                    end else begin
                        data0_r <= data1_r;
                        pc0_r   <= pc1_r;
                        data1_r <= imem_rdata;
                        pc1_r   <= inflight_pc_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: PC block and ROM models around the DUT, plus a
// reference of the expected instruction stream (next address after each consumed word).
module tb_fetch_ctrl;
    localparam int D = 9;
    localparam int W = 9;
`ifdef BRANCH_LUT_EN
    localparam int L = 5;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [D-1:0] start_addr = '0;
    logic [D-1:0] prog_ctr;
    logic         pc_hold, reljump_en, absjump_en;
    logic [D-1:0] target, imem_addr;
    logic [W-1:0] imem_rdata;
    logic         ins_valid;
    logic         ins_ready = 1'b0;
    logic [W-1:0] ins_data;
    logic [D-1:0] ins_pc;
    logic         br_valid = 1'b0, br_taken = 1'b0, br_rel = 1'b0;
    logic [D-1:0] br_off = '0, br_target = '0;
    logic         halt = 1'b0;
    logic         done;
`ifdef BRANCH_LUT_EN
    logic         lut_we = 1'b0;
    logic [L-1:0] lut_waddr = '0;
    logic [D-1:0] lut_wdata = '0;
    logic [D-1:0] lut_m [2**L];
`endif

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .prog_ctr(prog_ctr), .pc_hold(pc_hold), .reljump_en(reljump_en),
        .absjump_en(absjump_en), .target(target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_data(ins_data), .ins_pc(ins_pc), .br_valid(br_valid), .br_taken(br_taken),
        .br_rel(br_rel), .br_off(br_off), .br_target(br_target), .halt(halt), .done(done)
`ifdef BRANCH_LUT_EN
        , .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata)
`endif
    );

    function automatic logic [W-1:0] rom_f(input logic [D-1:0] a);
        logic [D-1:0] t;
        t = a + a + a;
        return t ^ 9'h15A;
    endfunction

    function automatic logic [D-1:0] abs_f(input logic [D-1:0] tg);
`ifdef BRANCH_LUT_EN
        return lut_m[tg[L-1:0]];
`else
        return tg;
`endif
    endfunction

    // Environment PC block
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        prog_ctr <= '0;
        else if (absjump_en) prog_ctr <= target;
        else if (reljump_en) prog_ctr <= prog_ctr + target;
        else if (!pc_hold)   prog_ctr <= prog_ctr + 9'd1;
    end

    // Environment synchronous ROM
    always_ff @(posedge clk) imem_rdata <= rom_f(imem_addr);

    int passed = 0;
    int total = 0;
    bit running = 1'b0;
    bit exp_done = 1'b1;
    logic [D-1:0] exp_pc = '0;
    int starve = 0;
    int max_starve = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // One cycle: drive at negedge, check at negedge+1, return at the next negedge
    task automatic step(input bit s, input logic [D-1:0] sa, input bit rdy, input bit bv,
                        input bit bt, input bit br, input logic [D-1:0] off,
                        input logic [D-1:0] tg, input bit h);
        logic [D-1:0] dest;
        logic [D-1:0] rel;
        bit pop;
        check("done", done, exp_done);
        start = s; start_addr = sa; ins_ready = rdy; br_valid = bv; br_taken = bt;
        br_rel = br; br_off = off; br_target = tg; halt = h;
        #1;
        pop = ins_valid && rdy;
        if (!running) check("idle_empty", ins_valid, 0);
        if (s) begin
            check("start_abs", absjump_en, 1);
            check("start_rel", reljump_en, 0);
            check("start_tgt", target, sa);
            running = 1'b1; exp_pc = sa; exp_done = 1'b0;
        end else if (pop) begin
            check("ins_pc", ins_pc, exp_pc);
            check("ins_data", ins_data, rom_f(exp_pc));
            if (h) begin
                check("halt_rel", reljump_en, 0);
                check("halt_abs", absjump_en, 0);
                running = 1'b0; exp_done = 1'b1;
            end else if (bv && bt) begin
                if (br) begin
                    dest = exp_pc + off;
                    rel = dest - prog_ctr;
                    check("rel_en", reljump_en, 1);
                    check("rel_abs", absjump_en, 0);
                    check("rel_tgt", target, rel);
                end else begin
                    dest = abs_f(tg);
                    check("abs_en", absjump_en, 1);
                    check("abs_rel", reljump_en, 0);
                    check("abs_tgt", target, dest);
                end
                exp_pc = dest;
            end else begin
                check("seq_rel", reljump_en, 0);
                check("seq_abs", absjump_en, 0);
                exp_pc = exp_pc + 9'd1;
            end
        end else begin
            check("nopop_rel", reljump_en, 0);
            check("nopop_abs", absjump_en, 0);
        end
        if (running && rdy && !s) begin
            if (ins_valid) starve = 0;
            else begin
                starve++;
                if (starve > max_starve) max_starve = starve;
            end
        end else if (s) starve = 0;
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 8 && !ins_valid; i++) run(1, 1'b1);
        check("wait_valid", ins_valid, 1);
    endtask

    initial begin
        logic [D-1:0] abs_sel;
        bit s, rdy, bv, h;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold", pc_hold, 1);
        check("rst_done", done, 1);
        check("rst_valid", ins_valid, 0);
        check("rst_rel", reljump_en, 0);
        check("rst_abs", absjump_en, 0);
        check("rst_tgt", target, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
`ifdef BRANCH_LUT_EN
        lut_we = 1'b1;
        for (int i = 0; i < 2**L; i++) begin
            lut_waddr = L'(i);
            lut_wdata = (i == 3) ? 9'h080 : D'($urandom_range(0, 511));
            lut_m[i] = lut_wdata;
            @(negedge clk);
        end
        lut_we = 1'b0;
        abs_sel = 9'd3;
`else
        abs_sel = 9'h080;
`endif
        // Start at 0x010, stream until head is 0x014, then branch back by 4
        step(1'b1, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 20 && !(ins_valid && ins_pc == 9'h014); i++) run(1, 1'b1);
        check("reach_014", ins_pc, 9'h014);
        check("pc_016", prog_ctr, 9'h016);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 9'h1FC, '0, 1'b0);
        wait_valid();
        check("after_rel", ins_pc, 9'h010);
        run(4, 1'b1);
        // Decode stall: buffer fills and PC is held
        run(5, 1'b0);
        check("stall_hold", pc_hold, 1);
        check("stall_valid", ins_valid, 1);
        run(8, 1'b1);
        // Absolute branch and a not-taken branch
        wait_valid();
        step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, abs_sel, 1'b0);
        wait_valid();
        check("after_abs", ins_pc, 9'h080);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 9'h040, '0, 1'b0);
        run(4, 1'b1);
        // Address wrap
        step(1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        run(6, 1'b1);
        // Halt wins over a taken branch; start then clears done
        wait_valid();
        step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 9'h005, '0, 1'b1);
        run(3, 1'b1);
        step(1'b1, 9'h020, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        run(5, 1'b1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            s = running ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) == 0);
            bv = ($urandom_range(0, 2) == 0);
            h = ($urandom_range(0, 39) == 0);
            step(s, D'($urandom_range(0, 511)), rdy, bv, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), D'($urandom_range(0, 511)),
                 D'($urandom_range(0, 511)), h);
        end
        // Reset in the middle of a run
        step(1'b1, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        run(4, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_hold", pc_hold, 1);
        check("mid_rst_done", done, 1);
        check("mid_rst_valid", ins_valid, 0);
        check("mid_rst_rel", reljump_en, 0);
        check("mid_rst_abs", absjump_en, 0);
        running = 1'b0;
        exp_done = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(2, 1'b1);
        step(1'b1, 9'h033, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        run(6, 1'b1);
        check("starve_bound", (max_starve <= 3), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
